// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and defaults for the run-time clock divider controller.
// Optional status outputs are built when CLK_DIV_CTRL_STATUS_EN is defined.
package clk_div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ     = 2;
  localparam int DEF_CNT_W       = 10;
  localparam int DEF_DEFAULT_TOP = 19;
  localparam int UPD_CNT_W       = 8;

  // Requester index width; a single requester still gets one bit.
  function automatic int gid_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Divisor change request bus between requesters (master) and the controller (slave).
interface clk_div_ctrl_if
  import clk_div_ctrl_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int CNT_W   = DEF_CNT_W
) ();

  // Handshake: requester i transfers req_top slice i on a clock edge where
  // req_valid[i] & req_ready[i]; req_ready is a one-hot grant, and a requester
  // holds req_valid and its req_top slice stable until that edge.
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*CNT_W-1:0] req_top;
  logic [NUM_REQ-1:0]       req_ready;

  modport master (
    output req_valid,
    output req_top,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_top,
    output req_ready
  );

endinterface

// File: rtl/clk_div_ctrl_div_core.sv
// Divider datapath: counter, toggling output and the TOP currently in use.
module div_core
  import clk_div_ctrl_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_TOP = DEF_DEFAULT_TOP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             load,
  input  logic [CNT_W-1:0] load_top,
  output logic             tc,
  output logic             sig,
  output logic [CNT_W-1:0] active_top
);

  logic [CNT_W-1:0] cnt;

  assign tc = run && (cnt == active_top);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      sig        <= 1'b0;
      active_top <= CNT_W'(DEFAULT_TOP);
    end else begin
      // Stopping wins over a coincident terminal count: output parks low.
      if (!run) begin
        cnt <= '0;
        sig <= 1'b0;
      end else if (tc) begin
        cnt <= '0;
        sig <= ~sig;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (load) begin
        active_top <= load_top;
      end
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Divider controller: round-robin request arbiter plus FSM that applies TOP only at a boundary.
// Defining CLK_DIV_CTRL_STATUS_EN adds the upd_pulse / upd_cnt status outputs.
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_TOP = DEF_DEFAULT_TOP
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  clk_div_ctrl_if.slave                  req,
  output logic                           sig,
  output logic [CNT_W-1:0]               active_top,
  output logic                           busy,
  output logic [gid_width(NUM_REQ)-1:0]  grant_id,
  output state_t                         state
`ifdef CLK_DIV_CTRL_STATUS_EN
  ,
  output logic                           upd_pulse,
  output logic [UPD_CNT_W-1:0]           upd_cnt
`endif
);

  localparam int GID_W = gid_width(NUM_REQ);

  logic [CNT_W-1:0]   top_arr [NUM_REQ];
  logic [NUM_REQ-1:0] grant_oh;
  logic [GID_W-1:0]   grant_idx;
  logic [GID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   sel_top;
  logic [CNT_W-1:0]   pend_top;
  logic [CNT_W-1:0]   load_top;
  logic               found;
  logic               arb_en;
  logic               accept;
  logic               run;
  logic               load;
  logic               tc;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_top
    assign top_arr[g] = req.req_top[g*CNT_W +: CNT_W];
  end

  // Round-robin: try offsets 1..NUM_REQ from the last grant, first valid wins.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req.req_valid[i] && (i == (int'(rr_ptr) + k) % NUM_REQ)) begin
          found       = 1'b1;
          grant_oh[i] = 1'b1;
          grant_idx   = GID_W'(i);
        end
      end
    end
  end

  assign sel_top       = top_arr[grant_idx];
  assign arb_en        = rst && ((state == IDLE) || (state == RUN));
  assign req.req_ready = arb_en ? grant_oh : '0;
  assign accept        = arb_en && found;
  assign run           = en && (state != IDLE);

  // Immediate apply when not counting (IDLE, or RUN being stopped); else wait in PEND.
  assign load     = (state == PEND) ? (!en || tc)
                                    : (accept && ((state == IDLE) || !en));
  assign load_top = (state == PEND) ? pend_top : sel_top;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      pend_top <= '0;
      grant_id <= '0;
      rr_ptr   <= GID_W'(NUM_REQ - 1);
    end else begin
      if (accept) begin
        rr_ptr   <= grant_idx;
        grant_id <= grant_idx;
        pend_top <= sel_top;
      end
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (en) state <= RUN;
        end
        RUN: begin
          if (!en) begin
            state <= IDLE;
          end else if (accept) begin
            state <= PEND;
            busy  <= 1'b1;
          end
        end
        PEND: begin
          if (!en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (tc) begin
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  div_core #(
    .CNT_W      (CNT_W),
    .DEFAULT_TOP(DEFAULT_TOP)
  ) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .load      (load),
    .load_top  (load_top),
    .tc        (tc),
    .sig       (sig),
    .active_top(active_top)
  );

`ifdef CLK_DIV_CTRL_STATUS_EN
  logic upd_change;

  assign upd_change = load && (load_top != active_top);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upd_pulse <= 1'b0;
      upd_cnt   <= '0;
    end else begin
      upd_pulse <= upd_change;
      if (upd_change && (upd_cnt != '1)) begin
        upd_cnt <= upd_cnt + UPD_CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Run-time controller for the programmable clock divider. Accepts divisor (TOP) change requests from several requesters, picks one with a round-robin arbiter, and reloads the divider only at a counter boundary, so the `sig` output never produces a runt or glitch pulse. Sits between firmware-facing register logic and the divided-clock consumers.

## Interface
- `NUM_REQ`, 2: number of requesters, 1..8
- `CNT_W`, 10: counter / TOP width in bits
- `DEFAULT_TOP`, 19: TOP loaded at reset

- `clk` in 1: system clock
- `rst` in 1: reset, asynchronous, active-low
- `en` in 1: divider run enable
- `req_valid` in NUM_REQ: per-requester change request
- `req_top` in NUM_REQ*CNT_W: requested TOP; requester i uses slice [i*CNT_W +: CNT_W]
- `req_ready` out NUM_REQ: one-hot grant; a transfer happens on an edge where `req_valid[i] & req_ready[i]`
- `sig` out 1: divided output
- `active_top` out CNT_W: TOP currently in use
- `busy` out 1: change accepted but not yet applied
- `grant_id` out $clog2(NUM_REQ) (min 1): index of the last accepted requester

## Operation
- Divider: `cnt` counts 0..active_top. When `cnt==active_top`, `cnt` returns to 0 and `sig` toggles. Output period is 2*(active_top+1) cycles. TOP=0 is legal and gives clk/2.
- States (held in registers):
  - `IDLE`: `en=0`; `cnt=0`; `sig=0`.
  - `RUN`: counting.
  - `PEND`: counting, with `pend_top` held.
- Transitions:
  - IDLE→RUN when `en=1`; counting starts at `cnt=0` on the next cycle.
  - RUN→PEND when a request is accepted.
  - PEND→RUN on the terminal count (`cnt==active_top`). That same edge loads `active_top<=pend_top`, clears `cnt` and toggles `sig`.
  - RUN or PEND→IDLE when `en=0`. If leaving PEND, `pend_top` is applied to `active_top` on that edge.
- Arbitration:
  - `req_ready` is combinational and non-zero only in IDLE or RUN.
  - Round-robin: search starts at the index after the last grant, wrapping from NUM_REQ-1 to 0.
  - In IDLE, an accepted TOP is written to `active_top` on the accept edge. The FSM stays in IDLE, and `busy` never asserts.
  - In PEND, all `req_ready` are 0. Requesters must hold `req_valid` and `req_top` stable until they are granted.
- Arithmetic: `cnt` and TOP are unsigned CNT_W bits. The comparison is equality only, so there is no wrap beyond TOP.

## Timing
- Reset values:
  - `sig=0`, `cnt=0`, `active_top=DEFAULT_TOP`, `busy=0`, `grant_id=0`.
  - State IDLE; round-robin pointer set so requester 0 has highest priority.
- `req_ready` to applied TOP:
  - IDLE: 1 edge.
  - RUN: at most active_top+1 edges (next terminal count).
- `busy` is 1 from the cycle after the accept edge up to and including the apply edge.
- A request accepted on the same edge as a terminal count (RUN) is applied at the following terminal count, not the current one.
- `en` falling while a terminal count occurs: IDLE takes priority. `sig=0` and `cnt=0` on that edge.
- Reset asserted mid-operation forces every register to its reset value immediately, including any pending request, which is dropped.

## Configuration
- `CLK_DIV_CTRL_STATUS_EN` defined adds two outputs:
  - `upd_pulse` (1 bit): high for one cycle after each edge that changes `active_top`.
  - `upd_cnt` (8 bits): saturates at 255 and clears on reset.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

## Structure
- Package `clk_div_ctrl_pkg`:
  - State enum (`IDLE`, `RUN`, `PEND`).
  - Default-parameter constants.
  - `UPD_CNT_W=8`.
- Sub-module `div_core`: holds `cnt` and `sig`.
  - Inputs: `run`, `load`, `load_top`.
  - Outputs: `tc` (terminal count), `sig`.
- The top level holds the FSM, the arbiter, `pend_top` and `grant_id`.

## Test plan
- Reset, then `en=1` with DEFAULT_TOP=19 at 100 MHz → `sig` rises 20 cycles after counting starts, period 40 cycles (2.5 MHz); `active_top=19`.
- In IDLE, req0 requests TOP=4 → `req_ready[0]` high the same cycle, `active_top=4` on the next edge, `busy` stays 0; after `en=1` the `sig` period is 10 cycles.
- RUN with TOP=19, req1 requests TOP=9 at `cnt=5` → `busy` for 14 cycles; the new period of 20 cycles starts exactly at the edge where `cnt` wraps from 19; no `sig` pulse is shorter than 10 cycles.
- req0 and req1 both valid and continuously held in IDLE → grants alternate 0,1,0,1; `grant_id` follows.
- PEND with TOP 19→3, deassert `en` at `cnt=7` → `sig=0`, `cnt=0`, `active_top=3`, `busy=0` on the next edge.
- Assert `rst` low mid-PEND → `active_top=19` and `sig=0` asynchronously, `req_ready=0`. With `CLK_DIV_CTRL_STATUS_EN`: `upd_cnt` returns to 0; 300 applied updates → `upd_cnt=255`.
